alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 64, operand/result width.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 reqN_valid  in  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  out  1  requester N's operation is accepted this cycle.
REQ-006 reqN_op  in  2  00 add, 01 sub (a-b), 10 and, 11 xor.
REQ-007 reqN_a, reqN_b  in  DATA_W  signed operands.
REQ-008 reqN_set_cc  in  1  operation updates condition codes.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer accepts the result.
REQ-011 rsp_id  out  1  index of the requester that owns the result.
REQ-012 rsp_result  out  DATA_W  ALU result.
REQ-013 rsp_overflow  out  1  signed overflow of that operation.
REQ-014 cc_zf, cc_sf, cc_of  out  1 each  condition-code register.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-016 In IDLE, if any reqN_valid is high, the block SHALL assert exactly one reqN_ready combinationally, capture that requester's op, a, b, set_cc and id, and enter EXEC.
REQ-017 Arbitration SHALL be round-robin: if both are valid, grant goes to the requester not granted last; after reset requester 0 has priority.
REQ-018 reqN_ready SHALL be low in EXEC and RESP, and low for the losing requester.
REQ-019 In EXEC the registered operands SHALL drive the alu sub-module; result and overflow SHALL be registered at the end of EXEC and the FSM SHALL enter RESP.
REQ-020 If captured set_cc=1, cc_zf=(result==0), cc_sf=result[DATA_W-1] and cc_of=overflow SHALL update on the same edge; otherwise CC holds.
REQ-021 In RESP, rsp_valid=1 with rsp_id/rsp_result/rsp_overflow stable until rsp_valid&&rsp_ready; then the FSM SHALL return to IDLE.
REQ-022 Grant-to-rsp_valid latency SHALL be 2 cycles; with rsp_ready held high, throughput SHALL be one operation per 3 cycles.
REQ-023 Arithmetic SHALL wrap modulo 2^DATA_W; overflow SHALL be set only for add/sub on signed overflow (add: same-sign operands, different-sign result; sub: different-sign operands, result sign differs from a); and/xor SHALL give overflow=0.
REQ-024 A requester dropping valid while not granted SHALL be ignored; no operation SHALL be issued without a valid&&ready cycle.

Reset
REQ-025 rst high on a clock edge SHALL force IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, cc_zf=1, cc_sf=0, cc_of=0, round-robin pointer to favour requester 0, from any state.
REQ-026 An operation in EXEC or RESP when rst asserts SHALL be discarded without a response or CC update.
REQ-027 reqN_ready SHALL be 0 while rst is high.

Structure
REQ-028 Op encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR), FSM state type and DATA_W default SHALL live in a shared package alu_pkg.
REQ-029 The combinational datapath SHALL be one instance of the existing sub-module alu (control, a, b, ans, overflow); the arbiter SHALL add no arithmetic of its own except the CC zero/sign detection.

Verification
REQ-030 Req0 add a=11,b=4 -> ready same cycle, rsp_valid 2 cycles later, result=15, rsp_id=0, overflow=0.
REQ-031 Req1 sub a=-11,b=4, set_cc=1 -> result=-15, cc_sf=1, cc_zf=0, cc_of=0; then xor a=11,b=11, set_cc=0 -> result=0, CC unchanged.
REQ-032 Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, one per 3 cycles.
REQ-033 add a=0x7FFF_FFFF_FFFF_FFFF,b=1, set_cc=1 -> result=0x8000_0000_0000_0000, overflow=1, cc_of=1, cc_sf=1; add a=2147483647,b=1 -> result=2147483648, overflow=0.
REQ-034 rsp_ready held low 5 cycles -> rsp_valid and outputs stable, both reqN_ready low, no new grant.
REQ-035 rst asserted during EXEC -> next cycle IDLE, rsp_valid=0, CC at reset values, next grant to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: the default datapath width,
// the op encodings and the arbiter FSM state constants.
package alu_pkg;

    localparam int DEFAULT_DATA_W = 64;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 2'b00;
    localparam alu_op_t ALU_SUB = 2'b01;
    localparam alu_op_t ALU_AND = 2'b10;
    localparam alu_op_t ALU_XOR = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU: add, sub, and, xor with signed-overflow flag.
module alu
    import alu_pkg::*;
#(
    parameter int W = DEFAULT_DATA_W
) (
    input  alu_op_t        control,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   ans,
    output logic           overflow
);

    // Result wraps modulo 2^W; overflow only meaningful for add/sub.
    always_comb begin
        ans      = '0;
        overflow = 1'b0;
        case (control)
            ALU_ADD: begin
                ans      = a + b;
                overflow = (a[W-1] == b[W-1]) && (ans[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                ans      = a - b;
                overflow = (a[W-1] != b[W-1]) && (ans[W-1] != a[W-1]);
            end
            ALU_AND: ans = a & b;
            ALU_XOR: ans = a ^ b;
            default: ans = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU. One operation
// is in flight at a time: IDLE grants, EXEC computes, RESP holds the result
// until the consumer takes it. Condition codes update when the result lands.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  alu_op_t           req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_set_cc,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  alu_op_t           req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_set_cc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_overflow,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of
);

    state_t            state;
    logic              last_grant;
    logic              grant_any;
    logic              grant_id;

    alu_op_t           op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              set_cc_q;
    logic              id_q;

    logic [DATA_W-1:0] alu_ans;
    logic              alu_ovf;

    // Pick a winner while idle; on contention favour whoever did not win last.
    always_comb begin
        grant_any = (state == ST_IDLE) && !rst && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
        req0_ready = grant_any && !grant_id;
        req1_ready = grant_any && grant_id;
    end

    // Latch the winning request; holds untouched for the rest of the operation.
    always_ff @(posedge clk) begin
        if (req0_ready) begin
            op_q     <= req0_op;
            a_q      <= req0_a;
            b_q      <= req0_b;
            set_cc_q <= req0_set_cc;
            id_q     <= 1'b0;
        end else if (req1_ready) begin
            op_q     <= req1_op;
            a_q      <= req1_a;
            b_q      <= req1_b;
            set_cc_q <= req1_set_cc;
            id_q     <= 1'b1;
        end
    end

    alu #(.W(DATA_W)) u_alu (
        .control  (op_q),
        .a        (a_q),
        .b        (b_q),
        .ans      (alu_ans),
        .overflow (alu_ovf)
    );

    // Sequencing, response registers and condition codes; reset drops any op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            cc_zf        <= 1'b1;
            cc_sf        <= 1'b0;
            cc_of        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        state      <= ST_EXEC;
                        last_grant <= grant_id;
                    end
                end
                ST_EXEC: begin
                    rsp_result   <= alu_ans;
                    rsp_overflow <= alu_ovf;
                    rsp_id       <= id_q;
                    if (set_cc_q) begin
                        cc_zf <= (alu_ans == '0);
                        cc_sf <= alu_ans[DATA_W-1];
                        cc_of <= alu_ovf;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == ST_RESP);

endmodule
